rf_wb_arbiter: RTL and testbench

//  Sequences and shares the single register-file write port. After reset, clears r1..r31 one

---
 rtl/rf_pkg.sv | 15 +
 rtl/rr_arb2.sv | 31 +++
 rtl/rf_wb_arbiter.sv | 111 +++++++++++
 tb/tb_rf_wb_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared widths, register-file constants and FSM encoding for the write-back arbiter.
package rf_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// 2-way round-robin grant, combinational from valid; 0-cycle latency.
// Backpressure: a losing requester simply sees no grant and must hold its request.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic last_grant;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    gnt0 = en & req0 & (~req1 | last_grant);
    gnt1 = en & req1 & (~req0 | ~last_grant);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (gnt0) begin
      last_grant <= 1'b0;
    end else if (gnt1) begin
      last_grant <= 1'b1;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port sequencer: post-reset clear sweep, then round-robin write-back.
// Latency: grant to rf_we is 1 cycle. Backpressure: ungranted requesters hold until ready.
module rf_wb_arbiter #(
  parameter int DATA_W         = rf_pkg::DATA_W,
  parameter int ADDR_W         = rf_pkg::ADDR_W,
  parameter int NUM_REGS       = rf_pkg::NUM_REGS,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              hazard,
  output logic              init_done
);

  import rf_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              run;
  logic              gnt0;
  logic              gnt1;
  logic              grant;
  logic              wr_real;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;
  logic              hit_a;
  logic              hit_b;

  assign run = (state == ST_RUN);

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .en   (run),
    .req0 (req0_valid),
    .req1 (req1_valid),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign grant      = gnt0 | gnt1;

  always_comb begin
    gnt_addr = gnt1 ? req1_addr : req0_addr;
    gnt_data = gnt1 ? req1_data : req0_data;
    wr_real  = grant && (gnt_addr != '0);
  end

  // Waiting producers count too, so decode stalls until the value lands.
  always_comb begin
    hit_a = (rd_addr_a != '0) &&
            ((req0_valid && (rd_addr_a == req0_addr)) ||
             (req1_valid && (rd_addr_a == req1_addr)) ||
             (rf_we      && (rd_addr_a == rf_waddr)));
    hit_b = (rd_addr_b != '0) &&
            ((req0_valid && (rd_addr_b == req0_addr)) ||
             (req1_valid && (rd_addr_b == req1_addr)) ||
             (rf_we      && (rd_addr_b == rf_waddr)));
    hazard = !run || hit_a || hit_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_cnt   <= ADDR_W'(1);
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      init_done <= !CLEAR_ON_RESET;
    end else begin
      case (state)
        ST_CLEAR: begin
          rf_we    <= 1'b1;
          rf_waddr <= clr_cnt;
          rf_wdata <= '0;
          clr_cnt  <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_REG) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        default: begin
          // r0 writes are accepted but never reach the register file.
          rf_we <= wr_real;
          if (wr_real) begin
            rf_waddr <= gnt_addr;
            rf_wdata <= gnt_data;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter: clear sweep, arbitration, r0, hazards, reset.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        hazard;
  logic        init_done;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .hazard     (hazard),
    .init_done  (init_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    req0_valid = 1'b0;
    req0_addr  = '0;
    req0_data  = '0;
    req1_valid = 1'b0;
    req1_addr  = '0;
    req1_data  = '0;
    rd_addr_a  = '0;
    rd_addr_b  = '0;

    // Reset, then the 31-cycle clear sweep with requests held off.
    tick;
    rst = 1'b0;
    chk("rst_we",    32'(rf_we),     32'd0);
    chk("rst_waddr", 32'(rf_waddr),  32'd0);
    chk("rst_wdata", rf_wdata,       32'd0);
    chk("rst_init",  32'(init_done), 32'd0);
    chk("rst_haz",   32'(hazard),    32'd1);
    req0_valid = 1'b1;
    req0_addr  = 5'd5;
    req1_valid = 1'b1;
    req1_addr  = 5'd6;
    #1;
    chk("clr_rdy0", 32'(req0_ready), 32'd0);
    chk("clr_rdy1", 32'(req1_ready), 32'd0);
    for (int i = 1; i <= 31; i++) begin
      tick;
      chk("clr_we",    32'(rf_we),     32'd1);
      chk("clr_waddr", 32'(rf_waddr),  32'(i));
      chk("clr_wdata", rf_wdata,       32'd0);
      chk("clr_init",  32'(init_done), (i == 31) ? 32'd1 : 32'd0);
      if (i < 31) begin
        chk("clr_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
      end
      if (i == 30) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end

    // Tie for four cycles: grants alternate 0,1,0,1 starting with req0.
    req0_valid = 1'b1;
    req0_addr  = 5'd3;
    req0_data  = 32'hA000_0000;
    req1_valid = 1'b1;
    req1_addr  = 5'd4;
    req1_data  = 32'hB000_0000;
    rd_addr_a  = 5'd3;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_rdy0", 32'(req0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_rdy1", 32'(req1_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k == 0) chk("rr_haz_pend", 32'(hazard), 32'd1);
      tick;
      chk("rr_we",    32'(rf_we),    32'd1);
      chk("rr_waddr", 32'(rf_waddr), (k % 2 == 0) ? 32'd3 : 32'd4);
      chk("rr_wdata", rf_wdata,
          (k % 2 == 0) ? (32'hA000_0000 + 32'(k / 2)) : (32'hB000_0000 + 32'(k / 2)));
      if (k % 2 == 0) req0_data = 32'hA000_0000 + 32'(k / 2 + 1);
      else            req1_data = 32'hB000_0000 + 32'(k / 2 + 1);
      if (k == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rd_addr_a  = '0;
      end
    end
    tick;
    chk("idle_we",  32'(rf_we),  32'd0);
    chk("idle_haz", 32'(hazard), 32'd0);

    // Single requester 0.
    req0_valid = 1'b1;
    req0_addr  = 5'd5;
    req0_data  = 32'hDEAD_BEEF;
    #1;
    chk("one_rdy0", 32'(req0_ready), 32'd1);
    chk("one_rdy1", 32'(req1_ready), 32'd0);
    tick;
    req0_valid = 1'b0;
    chk("one_we",    32'(rf_we),    32'd1);
    chk("one_waddr", 32'(rf_waddr), 32'd5);
    chk("one_wdata", rf_wdata,      32'hDEAD_BEEF);
    tick;
    chk("hold_we",    32'(rf_we),    32'd0);
    chk("hold_waddr", 32'(rf_waddr), 32'd5);
    chk("hold_wdata", rf_wdata,      32'hDEAD_BEEF);

    // Write to r0: accepted, never written, never a hazard.
    req1_valid = 1'b1;
    req1_addr  = 5'd0;
    req1_data  = 32'h0000_1234;
    #1;
    chk("r0_rdy1", 32'(req1_ready), 32'd1);
    chk("r0_haz",  32'(hazard),     32'd0);
    tick;
    req1_valid = 1'b0;
    chk("r0_we", 32'(rf_we), 32'd0);

    // Hazard on source B while pending and while in flight.
    req0_valid = 1'b1;
    req0_addr  = 5'd7;
    req0_data  = 32'h0000_0077;
    rd_addr_b  = 5'd7;
    #1;
    chk("hz_rdy0", 32'(req0_ready), 32'd1);
    chk("hz_pend", 32'(hazard),     32'd1);
    tick;
    req0_valid = 1'b0;
    #1;
    chk("hz_we",     32'(rf_we),    32'd1);
    chk("hz_waddr",  32'(rf_waddr), 32'd7);
    chk("hz_flight", 32'(hazard),   32'd1);
    tick;
    chk("hz_clear",  32'(hazard),   32'd0);
    rd_addr_b = '0;

    // Reset in the middle of the sweep restarts it at r1.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst2_we",   32'(rf_we),     32'd0);
    chk("rst2_init", 32'(init_done), 32'd0);
    for (int i = 1; i <= 11; i++) tick;
    chk("mid_waddr", 32'(rf_waddr), 32'd11);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_rst_we",    32'(rf_we),    32'd0);
    chk("mid_rst_waddr", 32'(rf_waddr), 32'd0);
    tick;
    chk("restart_we",    32'(rf_we),    32'd1);
    chk("restart_waddr", 32'(rf_waddr), 32'd1);
    for (int i = 2; i <= 31; i++) tick;
    chk("resweep_waddr", 32'(rf_waddr),  32'd31);
    chk("resweep_init",  32'(init_done), 32'd1);

    // Reset on the same edge as a grant drops the write.
    req0_valid = 1'b1;
    req0_addr  = 5'd9;
    req0_data  = 32'h0000_0099;
    #1;
    chk("rg_rdy0", 32'(req0_ready), 32'd1);
    rst = 1'b1;
    tick;
    rst        = 1'b0;
    req0_valid = 1'b0;
    chk("rg_we",   32'(rf_we),     32'd0);
    chk("rg_init", 32'(init_done), 32'd0);
    chk("rg_haz",  32'(hazard),    32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
